id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and operand-delivery stage of the RISC-V pipeline; drives the ALU in1/in2/sl inputs directly.
//  Registers decoded operands and controls, forwards results from MEM/WB, detects load-use hazards and inserts bubbles.
//  Also handles the branch flush and keeps a saturating bubble counter for performance debug.
// PARAMETERS
//  XLEN     32  datapath width
//  REGW     5   register-index width
//  CNTW     16  bubble counter width
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     reset, asynchronous, active-low
//  id_valid       in   1     ID holds a real instruction
//  id_rs1/id_rs2  in   REGW  source indices
//  id_use_rs2     in   1     instruction reads rs2 (R-type, store, branch)
//  id_rd          in   REGW  destination index
//  id_rd1/id_rd2  in   XLEN  register-file read data
//  id_imm         in   XLEN  sign-extended immediate
//  id_alu_src     in   1     0: in2 = rs2 operand; 1: in2 = imm
//  id_alu_sl      in   3     ALU op (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT)
//  id_reg_write   in   1     writes rd
//  id_mem_read    in   1     load
//  id_mem_write   in   1     store
//  mem_rd, wb_rd  in   REGW  destination of instr in MEM / WB
//  mem_reg_write, wb_reg_write  in 1  those instrs write rd
//  mem_result, wb_result        in XLEN  forwardable values
//  ex_hold        in   1     downstream stall; freeze this stage
//  flush          in   1     taken branch/jump; kill the instruction entering EX
//  stall_o        out  1     load-use stall to PC/IF-ID (combinational)
//  ex_valid       out  1     EX holds a real instruction
//  ex_rd          out  REGW
//  ex_reg_write, ex_mem_read, ex_mem_write  out 1  gated by ex_valid
//  alu_in1, alu_in2  out XLEN  forwarded ALU operands (combinational from regs + fwd)
//  alu_sl         out  3     registered ALU op
//  ex_store_data  out  XLEN  forwarded rs2 value for stores
//  bubble_cnt     out  CNTW  bubbles inserted since reset, saturating
// BEHAVIOUR
//  Reset (rst=0, async): all stage regs 0, so ex_valid=0, controls 0, alu_sl=000 (ADD), bubble_cnt=0.
//  Latency: ID inputs appear on EX outputs one clock later.
//  Load-use: stall_o = id_valid & ex_valid & ex_mem_read & ex_rd!=0 &
//   (ex_rd==id_rs1 | (id_use_rs2 & ex_rd==id_rs2)). stall_o is forced to 0 when flush=1 or ex_hold=1.
//  Edge update priority:
//   1. flush: load a bubble.
//   2. ex_hold: keep all regs.
//   3. stall_o: load a bubble.
//   4. otherwise: load ID fields, with ex_valid=id_valid.
//  Bubble: ex_valid=0, all controls 0, rd=0, alu_sl=000, data regs 0.
//  bubble_cnt increments by 1 per cycle in which case 1 or 3 loads a bubble; it sticks at 2^CNTW-1.
//  Forwarding of the rs1 operand (same rule for rs2):
//   - MEM match if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1 -> mem_result.
//   - else WB match (same test on wb_rd) -> wb_result.
//   - else the registered rd1 value.
//   - MEM beats WB when both match.
//   - Register x0 is never forwarded; its operand stays the registered value (0 from the regfile).
//  alu_in1 = fwd_rs1. alu_in2 = ex_alu_src ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2 regardless of alu_src.
//  Forwarding is also evaluated during ex_hold, so operands follow MEM/WB changes while frozen.
//  All arithmetic is done by the ALU; this block only selects. No width extension is needed.
// TESTING
//  - rst low mid-stream with ex_valid=1: outputs go 0 immediately (no clock); bubble_cnt=0.
//  - Back-to-back dependent ADDs (x5=x1+x2; x6=x5+x3), mem_result=0x10: alu_in1=0x10 via MEM forward.
//  - MEM and WB both write x7 (0xAA / 0xBB), EX reads x7: alu_in1=0xAA. With rd=x0 for both: alu_in1=id_rd1 value.
//  - LW x4 then ADD x8,x4,x1: stall_o=1 for one cycle, one bubble, bubble_cnt 0->1, ADD issues the next cycle.
//  - flush=1 and stall_o condition in the same cycle: stall_o=0, bubble loaded, bubble_cnt +1.
//  - ex_hold=1 for 3 cycles: EX regs frozen while ID changes. Force bubble_cnt to max-1, cause 2 bubbles: ends at max.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble
// insertion, branch flush and a saturating bubble counter.
module id_ex_operand_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic            id_use_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic [XLEN-1:0] id_rd1,
   input  logic [XLEN-1:0] id_rd2,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_alu_src,
   input  logic [2:0]      id_alu_sl,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic [REGW-1:0] mem_rd,
   input  logic [REGW-1:0] wb_rd,
   input  logic            mem_reg_write,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] mem_result,
   input  logic [XLEN-1:0] wb_result,
   input  logic            ex_hold,
   input  logic            flush,
   output logic            stall_o,
   output logic            ex_valid,
   output logic [REGW-1:0] ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   output logic [2:0]      alu_sl,
   output logic [XLEN-1:0] ex_store_data,
   output logic [CNTW-1:0] bubble_cnt
);

   logic [REGW-1:0] ex_rs1, ex_rs2;
   logic [XLEN-1:0] ex_rd1, ex_rd2, ex_imm;
   logic            ex_alu_src;
   logic            rw_r, mr_r, mw_r;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;
   logic            load_bubble;

   assign ex_reg_write = ex_valid & rw_r;
   assign ex_mem_read  = ex_valid & mr_r;
   assign ex_mem_write = ex_valid & mw_r;

   // A flush or hold suppresses the stall so IF/ID is not frozen needlessly.
   assign stall_o = id_valid & ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2))) &
                    ~flush & ~ex_hold;

   assign load_bubble = flush | stall_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid   <= 1'b0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_rd      <= '0;
         ex_rd1     <= '0;
         ex_rd2     <= '0;
         ex_imm     <= '0;
         ex_alu_src <= 1'b0;
         alu_sl     <= '0;
         rw_r       <= 1'b0;
         mr_r       <= 1'b0;
         mw_r       <= 1'b0;
      end else if (load_bubble) begin
         ex_valid   <= 1'b0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_rd      <= '0;
         ex_rd1     <= '0;
         ex_rd2     <= '0;
         ex_imm     <= '0;
         ex_alu_src <= 1'b0;
         alu_sl     <= '0;
         rw_r       <= 1'b0;
         mr_r       <= 1'b0;
         mw_r       <= 1'b0;
      end else if (!ex_hold) begin
         ex_valid   <= id_valid;
         ex_rs1     <= id_rs1;
         ex_rs2     <= id_rs2;
         ex_rd      <= id_rd;
         ex_rd1     <= id_rd1;
         ex_rd2     <= id_rd2;
         ex_imm     <= id_imm;
         ex_alu_src <= id_alu_src;
         alu_sl     <= id_alu_sl;
         rw_r       <= id_reg_write;
         mr_r       <= id_mem_read;
         mw_r       <= id_mem_write;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         bubble_cnt <= '0;
      else if (load_bubble && bubble_cnt != '1)
         bubble_cnt <= bubble_cnt + CNTW'(1);
   end

   // MEM has the younger result, so it is checked before WB; x0 never forwards.
   always_comb begin
      fwd_rs1 = ex_rd1;
      if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs1)
         fwd_rs1 = mem_result;
      else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs1)
         fwd_rs1 = wb_result;
   end

   always_comb begin
      fwd_rs2 = ex_rd2;
      if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs2)
         fwd_rs2 = mem_result;
      else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs2)
         fwd_rs2 = wb_result;
   end

   assign alu_in1       = fwd_rs1;
   assign alu_in2       = ex_alu_src ? ex_imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;

endmodule
